// File: rtl/gray_updown_counter.sv
// Parametrised up/down Gray-code counter with enable, synchronous load,
// wrap/saturate end handling, boundary flags and a binary shadow count.
module gray_updown_counter #(
  parameter int unsigned WIDTH     = 3,
  parameter int unsigned SATURATE  = 0,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] gray_out,
  output logic [WIDTH-1:0] bin_out,
  output logic             at_min,
  output logic             at_max,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_VAL   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] RESET_BIN = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] RESET_GRY = RESET_BIN ^ (RESET_BIN >> 1);

  logic [WIDTH-1:0] bin_d;
  logic [WIDTH-1:0] gray_d;
  logic             wrap_d;

  // Next count: load beats enable; ends either wrap (with pulse) or hold.
  always_comb begin
    bin_d  = bin_out;
    wrap_d = 1'b0;
    if (load) begin
      bin_d = load_val;
    end else if (en) begin
      if (!dir) begin
        if (bin_out == MAX_VAL) begin
          if (SATURATE == 0) begin
            bin_d  = '0;
            wrap_d = 1'b1;
          end
        end else begin
          bin_d = bin_out + WIDTH'(1);
        end
      end else begin
        if (bin_out == '0) begin
          if (SATURATE == 0) begin
            bin_d  = MAX_VAL;
            wrap_d = 1'b1;
          end
        end else begin
          bin_d = bin_out - WIDTH'(1);
        end
      end
    end
    gray_d = bin_d ^ (bin_d >> 1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bin_out  <= RESET_BIN;
      gray_out <= RESET_GRY;
      wrap     <= 1'b0;
    end else begin
      bin_out  <= bin_d;
      gray_out <= gray_d;
      wrap     <= wrap_d;
    end
  end

  // Boundary flags decode the registered count directly, so they track reset and load.
  assign at_min = (bin_out == '0);
  assign at_max = (bin_out == MAX_VAL);

endmodule

// File: tb/tb_gray_updown_counter.sv
// Bench for gray_updown_counter: a wrapping and a saturating instance share
// stimulus; directed vector table, reset corners, then random vs. a model.
module tb_gray_updown_counter;

  logic       clk = 1'b0;
  logic       clk_run = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       dir = 1'b0;
  logic       load = 1'b0;
  logic [2:0] load_val = 3'd0;

  logic [2:0] gray0, bin0, gray1, bin1;
  logic       min0, max0, wrap0, min1, max1, wrap1;

  int total = 0;
  int bad   = 0;

  gray_updown_counter #(.WIDTH(3), .SATURATE(0), .RESET_VAL(0)) dut_wrap (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_val(load_val),
    .gray_out(gray0), .bin_out(bin0), .at_min(min0), .at_max(max0), .wrap(wrap0)
  );

  gray_updown_counter #(.WIDTH(3), .SATURATE(1), .RESET_VAL(0)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_val(load_val),
    .gray_out(gray1), .bin_out(bin1), .at_min(min1), .at_max(max1), .wrap(wrap1)
  );

  initial begin
    wait (clk_run);
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       en;
    logic       dir;
    logic       ld;
    logic [2:0] lv;
    logic [2:0] b0;
    logic [2:0] g0;
    logic       w0;
    logic [2:0] b1;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int to_gray(input int b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk_reset_state(input string tag);
    chk({tag, " bin0"}, int'(bin0), 0);
    chk({tag, " gray0"}, int'(gray0), 0);
    chk({tag, " wrap0"}, int'(wrap0), 0);
    chk({tag, " at_min0"}, int'(min0), 1);
    chk({tag, " at_max0"}, int'(max0), 0);
    chk({tag, " bin1"}, int'(bin1), 0);
    chk({tag, " gray1"}, int'(gray1), 0);
    chk({tag, " wrap1"}, int'(wrap1), 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected next state from the counting rules, using plain integer arithmetic.
  task automatic model_step(input int cur, input bit sat, input bit e, input bit d,
                            input bit l, input int lv, output int nxt, output bit w);
    int n;
    w = 1'b0;
    if (l) begin
      nxt = lv;
    end else if (e) begin
      n = d ? cur - 1 : cur + 1;
      if (n < 0 || n > 7) begin
        if (sat) nxt = cur;
        else begin
          nxt = (n + 8) % 8;
          w   = 1'b1;
        end
      end else begin
        nxt = n;
      end
    end else begin
      nxt = cur;
    end
  endtask

  initial begin
    int m0, m1, n0, n1, lvr;
    bit w0, w1, er, dr, lr;
    logic [2:0] pg0, pg1;

    // Reset with the clock stopped
    #1 rst = 1'b0;
    #1 chk_reset_state("reset");

    // Release between edges: no change until the first rising edge
    en = 1'b1; dir = 1'b0;
    clk_run = 1'b1;
    #1 rst = 1'b1;
    #1 chk("release hold bin0", int'(bin0), 0);
    step();
    chk("first step bin0", int'(bin0), 1);
    chk("first step bin1", int'(bin1), 1);

    //            en    dir   ld    lv    b0    g0       w0    b1
    vecs.push_back('{1'b0, 1'b0, 1'b1, 3'd0, 3'd0, 3'b000, 1'b0, 3'd0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 3'd0, 3'd1, 3'b001, 1'b0, 3'd1});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 3'd0, 3'd2, 3'b011, 1'b0, 3'd2});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 3'd0, 3'd3, 3'b010, 1'b0, 3'd3});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 3'd0, 3'd4, 3'b110, 1'b0, 3'd4});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 3'd0, 3'd5, 3'b111, 1'b0, 3'd5});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 3'd0, 3'd6, 3'b101, 1'b0, 3'd6});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 3'd0, 3'd7, 3'b100, 1'b0, 3'd7});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 3'b000, 1'b1, 3'd7});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 3'd0, 3'd1, 3'b001, 1'b0, 3'd7});
    // down from 0
    vecs.push_back('{1'b0, 1'b0, 1'b1, 3'd0, 3'd0, 3'b000, 1'b0, 3'd0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 3'd0, 3'd7, 3'b100, 1'b1, 3'd0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 3'd0, 3'd6, 3'b101, 1'b0, 3'd0});
    // saturate at max, then turn around
    vecs.push_back('{1'b0, 1'b0, 1'b1, 3'd7, 3'd7, 3'b100, 1'b0, 3'd7});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 3'b000, 1'b1, 3'd7});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 3'd0, 3'd1, 3'b001, 1'b0, 3'd7});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 3'd0, 3'd2, 3'b011, 1'b0, 3'd7});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 3'd0, 3'd1, 3'b001, 1'b0, 3'd6});
    // load beats en/dir, then counting resumes
    vecs.push_back('{1'b0, 1'b0, 1'b1, 3'd2, 3'd2, 3'b011, 1'b0, 3'd2});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 3'd5, 3'd5, 3'b111, 1'b0, 3'd5});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 3'd0, 3'd6, 3'b101, 1'b0, 3'd6});
    // hold, then a same-edge direction change
    vecs.push_back('{1'b0, 1'b1, 1'b0, 3'd0, 3'd6, 3'b101, 1'b0, 3'd6});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 3'd0, 3'd7, 3'b100, 1'b0, 3'd7});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 3'd0, 3'd6, 3'b101, 1'b0, 3'd6});

    foreach (vecs[i]) begin
      en = vecs[i].en; dir = vecs[i].dir; load = vecs[i].ld; load_val = vecs[i].lv;
      step();
      chk($sformatf("vec%0d bin0", i), int'(bin0), int'(vecs[i].b0));
      chk($sformatf("vec%0d gray0", i), int'(gray0), int'(vecs[i].g0));
      chk($sformatf("vec%0d wrap0", i), int'(wrap0), int'(vecs[i].w0));
      chk($sformatf("vec%0d at_min0", i), int'(min0), int'(vecs[i].b0 == 3'd0));
      chk($sformatf("vec%0d at_max0", i), int'(max0), int'(vecs[i].b0 == 3'd7));
      chk($sformatf("vec%0d bin1", i), int'(bin1), int'(vecs[i].b1));
      chk($sformatf("vec%0d gray1", i), int'(gray1), to_gray(int'(vecs[i].b1)));
      chk($sformatf("vec%0d wrap1", i), int'(wrap1), 0);
      chk($sformatf("vec%0d at_max1", i), int'(max1), int'(vecs[i].b1 == 3'd7));
    end

    // Async reset mid-count, between edges
    en = 1'b1; dir = 1'b0; load = 1'b1; load_val = 3'd4;
    step();
    load = 1'b0;
    chk("pre-reset bin0", int'(bin0), 4);
    #2 rst = 1'b0;
    #1 chk_reset_state("async reset");
    step();
    chk_reset_state("reset held");
    #2 rst = 1'b1;

    // Random stimulus against the model
    m0 = 0; m1 = 0;
    for (int c = 0; c < 1000; c++) begin
      er  = 1'($urandom_range(0, 3) != 0);
      dr  = 1'($urandom_range(0, 1));
      lr  = 1'($urandom_range(0, 9) == 0);
      lvr = int'($urandom_range(0, 7));
      en = er; dir = dr; load = lr; load_val = 3'(lvr);
      pg0 = gray0; pg1 = gray1;
      model_step(m0, 1'b0, er, dr, lr, lvr, n0, w0);
      model_step(m1, 1'b1, er, dr, lr, lvr, n1, w1);
      step();
      chk("rand bin0", int'(bin0), n0);
      chk("rand gray0", int'(gray0), to_gray(n0));
      chk("rand wrap0", int'(wrap0), int'(w0));
      chk("rand at_min0", int'(min0), int'(n0 == 0));
      chk("rand at_max0", int'(max0), int'(n0 == 7));
      chk("rand bin1", int'(bin1), n1);
      chk("rand gray1", int'(gray1), to_gray(n1));
      chk("rand wrap1", int'(wrap1), int'(w1));
      if (!lr && n0 != m0) chk("rand onebit0", $countones(pg0 ^ gray0), 1);
      if (!lr && n1 != m1) chk("rand onebit1", $countones(pg1 ^ gray1), 1);
      m0 = n0; m1 = n1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
